// File: rtl/keypad_pkg.sv
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and helpers for the keypad transmit block: FSM
//             state encoding, key-code constants, row decode and keymap.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  // Controller states, shared so the top and any debug logic agree on encoding
  typedef enum logic [2:0] {
    SCAN  = 3'd0,
    DEB_P = 3'd1,
    PRESS = 3'd2,
    HELD  = 3'd3,
    DEB_R = 3'd4,
    REL   = 3'd5
  } state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // {valid, row_idx}: valid only when exactly one active-low row is asserted
  function automatic logic [2:0] row_decode(input logic [3:0] row);
    logic [2:0] res;
    case (row)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // Physical position to key code
  function automatic logic [3:0] keymap(input logic [1:0] row_idx,
                                        input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
//  Module   : keypad_scan
//  Purpose  : Column driver for the 4x4 matrix. Each column is driven for
//             SCAN_DIV cycles; the sample strobe marks the last cycle of the
//             slot. freeze holds the current column, advance moves to the
//             next column at once and restarts the slot timer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       advance,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div;

  assign sample = (div == DIV_W'(SCAN_DIV - 1));
  assign col    = ~(4'b0001 << col_idx);

  // Slot timer and column index; advance restarts the slot so the next
  // sample sees a full synchroniser delay under the new column
  always_ff @(posedge clk) begin
    if (!rst) begin
      div     <= '0;
      col_idx <= 2'd0;
    end else if (advance) begin
      div     <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div <= sample ? '0 : div + 1'b1;
      if (sample && !freeze) begin
        col_idx <= col_idx + 2'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_tx.sv
// ============================================================================
//  Module   : keypad_tx
//  Purpose  : Keypad transmit end. Scans a 4x4 active-low matrix, debounces
//             press and release of a single key and drives the
//             Keypressed / Keyreleased / charSent handshake.
//  Options  : KEYPAD_AUTOREPEAT_EN - when defined, a held key re-issues
//             Keypressed after REPEAT_DELAY cycles, then every REPEAT_RATE.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_tx
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 256,
  parameter int REPEAT_RATE  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       Keypressed,
  output logic       Keyreleased,
  output logic [3:0] charSent,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  // The synchroniser needs two cycles of the slot, the counter needs DEBOUNCE>=2
  if (SCAN_DIV < 3 || DEBOUNCE < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_tx: unsupported parameter set");
  end

  state_t           state, next_state;
  logic [3:0]       row_meta, row_sync;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       row_lat, row_lat_next;
  logic             load_char;
  logic             freeze, advance, sample;
  logic [1:0]       col_idx;
  logic [2:0]       decoded;
  logic             samp_valid;
  logic [1:0]       samp_row;
  logic             same_key;
  logic             rpt_fire;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .freeze  (freeze),
    .advance (advance),
    .col     (col),
    .col_idx (col_idx),
    .sample  (sample)
  );

  // Two-flop synchroniser; idle value is "all rows released"
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign decoded    = row_decode(row_sync);
  assign samp_valid = decoded[2];
  assign samp_row   = decoded[1:0];
  assign same_key   = samp_valid && (samp_row == row_lat);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;

  assign rpt_fire = (state == HELD) &&
                    (rpt_first ? (rpt_cnt == RPT_W'(REPEAT_DELAY - 1))
                               : (rpt_cnt == RPT_W'(REPEAT_RATE - 1)));

  // Repeat timer: restarts on a fresh press, runs in HELD, frozen in DEB_R
  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state == PRESS) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state == HELD) begin
      if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // State, debounce counter, latched row and reported key code
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SCAN;
      cnt      <= '0;
      row_lat  <= 2'd0;
      charSent <= 4'd0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      row_lat <= row_lat_next;
      if (load_char) begin
        charSent <= keymap(row_lat, col_idx);
      end
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state   = state;
    cnt_next     = cnt;
    row_lat_next = row_lat;
    load_char    = 1'b0;
    freeze       = 1'b1;
    advance      = 1'b0;
    Keypressed   = 1'b0;
    Keyreleased  = 1'b0;
    key_held     = 1'b0;
    case (state)
      SCAN: begin
        freeze = 1'b0;
        if (sample && samp_valid) begin
          freeze       = 1'b1;
          row_lat_next = samp_row;
          cnt_next     = CNT_W'(1);
          next_state   = DEB_P;
        end
      end
      DEB_P: begin
        if (sample) begin
          if (same_key) begin
            if (cnt == CNT_W'(DEBOUNCE - 1)) begin
              load_char  = 1'b1;
              next_state = PRESS;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end else begin
            advance    = 1'b1;
            next_state = SCAN;
          end
        end
      end
      PRESS: begin
        Keypressed = 1'b1;
        key_held   = 1'b1;
        next_state = HELD;
      end
      HELD: begin
        key_held   = 1'b1;
        Keypressed = rpt_fire;
        if (sample && !same_key) begin
          cnt_next   = CNT_W'(1);
          next_state = DEB_R;
        end
      end
      DEB_R: begin
        key_held = 1'b1;
        if (sample) begin
          if (same_key) begin
            next_state = HELD;
          end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
            next_state = REL;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      REL: begin
        Keyreleased = 1'b1;
        key_held    = 1'b1;
        advance     = 1'b1;
        next_state  = SCAN;
      end
      default: next_state = SCAN;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_tx.sv
// ============================================================================
//  Module   : tb_keypad_tx
//  Purpose  : Directed self-checking bench for keypad_tx. A small matrix
//             model turns the driven column and the set of pressed keys into
//             the active-low row inputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       Keypressed;
  logic       Keyreleased;
  logic [3:0] charSent;
  logic       key_held;

  // Pressed keys, bit index = row*4 + col
  logic [15:0] keys = 16'h0000;

  int assertions = 0;
  int failures   = 0;

  int         cyc    = 0;
  int         kp_cnt = 0;
  int         kr_cnt = 0;
  int         both_hi = 0;
  int         kp_time[$];
  logic [3:0] kp_code[$];

  always #5 clk = ~clk;

  keypad_tx dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .Keypressed  (Keypressed),
    .Keyreleased (Keyreleased),
    .charSent    (charSent),
    .key_held    (key_held)
  );

  // Matrix model: a row is pulled low through any pressed key on a driven column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Pulse recorder
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (Keypressed) begin
      kp_cnt <= kp_cnt + 1;
      kp_time.push_back(cyc);
      kp_code.push_back(charSent);
    end
    if (Keyreleased) kr_cnt <= kr_cnt + 1;
    if (Keypressed && Keyreleased) both_hi <= both_hi + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_kp(input int base, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick(1);
      if (kp_cnt > base) seen = 1'b1;
    end
  endtask

  // Wait for the first cycle of a column slot (column freshly driven)
  task automatic wait_col_start(input logic [3:0] target, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 64 && col == target; i++) tick(1);
    for (int i = 0; i < 64 && !seen; i++) begin
      tick(1);
      if (col == target) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    assertions++;
    if (col !== 4'b1110) begin
      failures++; $display("FAIL reset_col: got %b expected 1110", col);
    end
    assertions++;
    if (Keypressed !== 1'b0) begin
      failures++; $display("FAIL reset_keypressed: got %b expected 0", Keypressed);
    end
    assertions++;
    if (Keyreleased !== 1'b0) begin
      failures++; $display("FAIL reset_keyreleased: got %b expected 0", Keyreleased);
    end
    assertions++;
    if (charSent !== 4'd0) begin
      failures++; $display("FAIL reset_charsent: got %0d expected 0", charSent);
    end
    assertions++;
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL reset_key_held: got %b expected 0", key_held);
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_single_key;
    int kb, rb;
    kb = kp_cnt; rb = kr_cnt;
    keys = 16'h0001 << 5;                // '5'
    tick(300);
    assertions++;
    if (kp_cnt - kb !== 1) begin
      failures++; $display("FAIL single_press_count: got %0d expected 1", kp_cnt - kb);
    end
    assertions++;
    if (kp_cnt > kb && kp_code[kb] !== 4'd5) begin
      failures++; $display("FAIL single_press_code: got %0d expected 5", kp_code[kb]);
    end
    assertions++;
    if (key_held !== 1'b1) begin
      failures++; $display("FAIL single_key_held: got %b expected 1", key_held);
    end
    assertions++;
    if (kr_cnt - rb !== 0) begin
      failures++; $display("FAIL single_early_release: got %0d expected 0", kr_cnt - rb);
    end
    keys = 16'h0000;
    tick(100);
    assertions++;
    if (kr_cnt - rb !== 1) begin
      failures++; $display("FAIL single_release_count: got %0d expected 1", kr_cnt - rb);
    end
    assertions++;
    if (charSent !== 4'd5) begin
      failures++; $display("FAIL single_code_after_release: got %0d expected 5", charSent);
    end
    assertions++;
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL single_held_after_release: got %b expected 0", key_held);
    end
  endtask

  task automatic test_sequence;
    int         kb, rb;
    int         bits [4];
    logic [3:0] codes [4];
    bits  = '{0, 1, 2, 4};               // '1' '2' '3' '4'
    codes = '{4'd1, 4'd2, 4'd3, 4'd4};
    kb = kp_cnt; rb = kr_cnt;
    for (int i = 0; i < 4; i++) begin
      keys = 16'h0001 << bits[i];
      tick(100);
      keys = 16'h0000;
      tick(100);
    end
    assertions++;
    if (kp_cnt - kb !== 4) begin
      failures++; $display("FAIL seq_press_count: got %0d expected 4", kp_cnt - kb);
    end
    assertions++;
    if (kr_cnt - rb !== 4) begin
      failures++; $display("FAIL seq_release_count: got %0d expected 4", kr_cnt - rb);
    end
    for (int i = 0; i < 4; i++) begin
      if (kb + i < kp_cnt) begin
        assertions++;
        if (kp_code[kb+i] !== codes[i]) begin
          failures++; $display("FAIL seq_code_%0d: got %0d expected %0d", i, kp_code[kb+i], codes[i]);
        end
      end
    end
  endtask

  task automatic test_bounce;
    int kb, rb;
    bit seen;
    kb = kp_cnt; rb = kr_cnt;
    for (int n = 0; n < 2; n++) begin
      wait_col_start(4'b1011, seen);
      assertions++;
      if (!seen) begin
        failures++; $display("FAIL bounce_col_timeout: got col %b expected 1011", col);
      end
      keys = 16'h0001 << 14;             // '#': two low samples then a high one
      tick(8);
      keys = 16'h0000;
      tick(4);
    end
    tick(100);
    assertions++;
    if (kp_cnt - kb !== 0) begin
      failures++; $display("FAIL bounce_press_count: got %0d expected 0", kp_cnt - kb);
    end
    assertions++;
    if (kr_cnt - rb !== 0) begin
      failures++; $display("FAIL bounce_release_count: got %0d expected 0", kr_cnt - rb);
    end
  endtask

  task automatic test_two_keys;
    int kb, rb;
    kb = kp_cnt; rb = kr_cnt;
    keys = (16'h0001 << 0) | (16'h0001 << 4);  // '1' and '4', same column
    tick(150);
    assertions++;
    if (kp_cnt - kb !== 0) begin
      failures++; $display("FAIL two_keys_press_count: got %0d expected 0", kp_cnt - kb);
    end
    keys = 16'h0001 << 0;
    tick(100);
    assertions++;
    if (kp_cnt - kb !== 1) begin
      failures++; $display("FAIL two_keys_single_count: got %0d expected 1", kp_cnt - kb);
    end
    assertions++;
    if (kp_cnt > kb && kp_code[kb] !== 4'd1) begin
      failures++; $display("FAIL two_keys_code: got %0d expected 1", kp_code[kb]);
    end
    keys = 16'h0000;
    tick(100);
    assertions++;
    if (kr_cnt - rb !== 1) begin
      failures++; $display("FAIL two_keys_release_count: got %0d expected 1", kr_cnt - rb);
    end
  endtask

  task automatic test_reset_mid_hold;
    int kb, rb;
    bit seen;
    kb = kp_cnt; rb = kr_cnt;
    keys = 16'h0001 << 12;               // '*'
    wait_kp(kb, 100, seen);
    assertions++;
    if (!seen) begin
      failures++; $display("FAIL rst_hold_first_press: got %0d presses expected 1", kp_cnt - kb);
    end
    tick(20);
    rst = 1'b0;
    tick(1);
    assertions++;
    if (col !== 4'b1110) begin
      failures++; $display("FAIL rst_hold_col: got %b expected 1110", col);
    end
    assertions++;
    if (Keypressed !== 1'b0 || Keyreleased !== 1'b0) begin
      failures++; $display("FAIL rst_hold_pulses: got %b%b expected 00", Keypressed, Keyreleased);
    end
    assertions++;
    if (charSent !== 4'd0) begin
      failures++; $display("FAIL rst_hold_charsent: got %0d expected 0", charSent);
    end
    assertions++;
    if (key_held !== 1'b0) begin
      failures++; $display("FAIL rst_hold_key_held: got %b expected 0", key_held);
    end
    rst = 1'b1;
    kb = kp_cnt;
    wait_kp(kb, 100, seen);
    assertions++;
    if (!seen) begin
      failures++; $display("FAIL rst_hold_repress: got %0d presses expected 1", kp_cnt - kb);
    end
    assertions++;
    if (kp_cnt > kb && kp_code[kb] !== 4'd14) begin
      failures++; $display("FAIL rst_hold_code: got %0d expected 14", kp_code[kb]);
    end
    assertions++;
    if (kr_cnt - rb !== 0) begin
      failures++; $display("FAIL rst_hold_no_release: got %0d expected 0", kr_cnt - rb);
    end
    keys = 16'h0000;
    tick(100);
    assertions++;
    if (kr_cnt - rb !== 1) begin
      failures++; $display("FAIL rst_hold_release_count: got %0d expected 1", kr_cnt - rb);
    end
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat;
    int kb, rb;
    int gaps [4];
    gaps = '{256, 64, 64, 64};
    kb = kp_cnt; rb = kr_cnt;
    keys = 16'h0001 << 13;               // '0'
    tick(500);
    keys = 16'h0000;
    tick(100);
    assertions++;
    if (kp_cnt - kb !== 5) begin
      failures++; $display("FAIL rpt_press_count: got %0d expected 5", kp_cnt - kb);
    end
    assertions++;
    if (kr_cnt - rb !== 1) begin
      failures++; $display("FAIL rpt_release_count: got %0d expected 1", kr_cnt - rb);
    end
    for (int i = 0; i < 4; i++) begin
      if (kb + i + 1 < kp_cnt) begin
        assertions++;
        if (kp_time[kb+i+1] - kp_time[kb+i] !== gaps[i]) begin
          failures++; $display("FAIL rpt_gap_%0d: got %0d expected %0d", i, kp_time[kb+i+1] - kp_time[kb+i], gaps[i]);
        end
        assertions++;
        if (kp_code[kb+i+1] !== 4'd0) begin
          failures++; $display("FAIL rpt_code_%0d: got %0d expected 0", i, kp_code[kb+i+1]);
        end
      end
    end
  endtask
`endif

  task automatic test_exclusive;
    assertions++;
    if (both_hi !== 0) begin
      failures++; $display("FAIL pulse_overlap: got %0d overlapping cycles expected 0", both_hi);
    end
  endtask

  initial begin
    test_reset;
    test_single_key;
    test_sequence;
    test_bounce;
    test_two_keys;
    test_reset_mid_hold;
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat;
`endif
    test_exclusive;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
